// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the writeback port arbiter.
//   XLEN / REG_ADDR_W : datapath and register-address widths
//   wb_sel_e          : which source owns the register-file write port
//   reg_onehot        : one-hot decode of a register address
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    SEL_PIPE = 1'b0,
    SEL_LU   = 1'b1
  } wb_sel_e;

  function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    reg_onehot = XLEN'(1) << rd;
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback stage / long-latency unit and the
// register-file write port arbiter.
//   wb_*  : in-order pipeline writeback request
//   lu_*  : long-latency (mul/div) result handshake and pending mask
//   rf_*  : register-file write port, stall_o back to the pipeline
// Modports: slave = arbiter side, master = surrounding core side.
interface wb_port_arbiter_if;
  import riscv_pkg::*;

  logic                  wb_regwrite_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [XLEN-1:0]       wb_wdata_i;
  logic                  lu_valid_i;
  logic                  lu_ready_o;
  logic [REG_ADDR_W-1:0] lu_rd_i;
  logic [XLEN-1:0]       lu_wdata_i;
  logic                  rf_we_o;
  logic [REG_ADDR_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]       rf_wdata_o;
  logic                  stall_o;
  logic [XLEN-1:0]       lu_pending_o;

  modport slave (
    input  wb_regwrite_i, wb_rd_i, wb_wdata_i,
    input  lu_valid_i, lu_rd_i, lu_wdata_i,
    output lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, lu_pending_o
  );

  modport master (
    output wb_regwrite_i, wb_rd_i, wb_wdata_i,
    output lu_valid_i, lu_rd_i, lu_wdata_i,
    input  lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, lu_pending_o
  );
endinterface

// File: rtl/wb_result_fifo.sv
// Buffer of long-latency results {rd, data} awaiting the register-file port.
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_rd/data: enqueue (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   head_rd/data      : oldest entry
//   count, full, empty: occupancy
//   pending           : OR of one-hot(rd) over all buffered entries
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [REG_ADDR_W-1:0]      push_rd,
  input  logic [XLEN-1:0]            push_data,
  input  logic                       pop,
  output logic [REG_ADDR_W-1:0]      head_rd,
  output logic [XLEN-1:0]            head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [XLEN-1:0]            pending
);
  localparam int AW = $clog2(DEPTH);

  logic [REG_ADDR_W-1:0] mem_rd   [DEPTH];
  logic [XLEN-1:0]       mem_data [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           cnt;
  logic                  push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = cnt;

  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Per-entry valid bits let the pending mask be formed without walking
  // the pointer range; push and pop never hit the same slot in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_rd[wr_ptr]   <= push_rd;
        mem_data[wr_ptr] <= push_data;
        vld[wr_ptr]      <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) pending = pending | reg_onehot(mem_rd[i]);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and buffered long-latency results. The pipeline wins
// by default; after STARVE_LIMIT consecutive denials of a waiting result
// the pipeline is stalled for one cycle and the FIFO head is written.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : wb_port_arbiter_if.slave (wb_*, lu_*, rf_*, stall_o)
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_INIT = SW'(STARVE_LIMIT);

  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [XLEN-1:0]       pending;

  logic                  pipe_req, lu_push, lu_pop, force_lu;
  wb_sel_e               sel;
  // Remaining denials before the head is forced; zero is terminal count.
  logic [SW-1:0]         starve_left;
  logic                  starve_tc;

  assign pipe_req  = bus.wb_regwrite_i && (bus.wb_rd_i != '0);
  // rd=0 results complete the handshake but are never buffered.
  assign lu_push   = bus.lu_valid_i && !fifo_full && (bus.lu_rd_i != '0);
  assign starve_tc = (starve_left == '0);

  always_comb begin
    sel      = SEL_PIPE;
    force_lu = 1'b0;
    if (!fifo_empty) begin
      if (!pipe_req) begin
        sel = SEL_LU;
      end else if (starve_tc) begin
        sel      = SEL_LU;
        force_lu = 1'b1;
      end
    end
  end

  assign lu_pop = !fifo_empty && (sel == SEL_LU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_left <= STARVE_INIT;
    end else if (fifo_empty || lu_pop) begin
      starve_left <= STARVE_INIT;
    end else if (!starve_tc) begin
      starve_left <= starve_left - 1'b1;
    end
  end

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lu_push),
    .push_rd   (bus.lu_rd_i),
    .push_data (bus.lu_wdata_i),
    .pop       (lu_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pending   (pending)
  );

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign bus.lu_ready_o   = (fifo_count < CW'(FIFO_DEPTH));
  assign bus.rf_we_o      = rst && ((sel == SEL_LU) || pipe_req);
  assign bus.rf_waddr_o   = !rst ? '0 : (sel == SEL_LU) ? head_rd   : bus.wb_rd_i;
  assign bus.rf_wdata_o   = !rst ? '0 : (sel == SEL_LU) ? head_data : bus.wb_wdata_i;
  assign bus.stall_o      = rst && force_lu;
  assign bus.lu_pending_o = pending;
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and the long-latency execution unit (mul/div). It sits between the writeback stage and the register file. Long-latency results are buffered in a small FIFO, and the pipeline writeback normally has priority. A starvation counter forces a one-cycle pipeline stall so that buffered results always drain.

## Interface
Parameters:
- FIFO_DEPTH, 2: long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive denied cycles before the FIFO head is forced through (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_regwrite_i  in  1  pipeline writeback wants to write
- wb_rd_i  in  5  pipeline destination register
- wb_wdata_i  in  32  pipeline write data (already muxed mem/ALU)
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  arbiter can accept a long-latency result
- lu_rd_i  in  5  long-latency destination register
- lu_wdata_i  in  32  long-latency result
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- stall_o  out  1  pipeline must hold its writeback stage this cycle
- lu_pending_o  out  32  bit r set while any buffered entry targets register r

## Operation
- A pipeline request is valid when wb_regwrite_i=1 and wb_rd_i≠0. A request with rd=0 is ignored and never written.
- The FIFO pushes on lu_valid_i && lu_ready_o when lu_rd_i≠0. An accepted rd=0 result is consumed and dropped.
- lu_ready_o = (count < FIFO_DEPTH). It depends on the count only; there is no same-cycle pop-through.
- Grant rule for each cycle:
  - FIFO empty: the pipeline request, if any, is written.
  - FIFO non-empty, no valid pipeline request: the FIFO head is written and popped.
  - FIFO non-empty, valid pipeline request, starve < STARVE_LIMIT: the pipeline request is written and starve increments.
  - FIFO non-empty, valid pipeline request, starve = STARVE_LIMIT: the FIFO head is written and popped, and stall_o=1.
- starve resets to 0 when the head is popped or the FIFO is empty. It saturates at STARVE_LIMIT.
- While stall_o=1, the pipeline holds wb_* stable into the next cycle. The arbiter does not latch them.
- lu_pending_o is the OR of one-hot(rd) over valid entries. It is updated registered, with the FIFO.
- WAW ordering between buffered results and younger pipeline writes to the same rd is excluded by issue logic, which consults lu_pending_o. The arbiter does not check it.

## Timing
- rf_we_o, rf_waddr_o, rf_wdata_o and stall_o are combinational from the inputs and registered state. The pipeline write lands in the same cycle it is presented (zero added latency).
- Long-latency result accepted at edge t: the earliest write is cycle t+1. The worst-case wait is STARVE_LIMIT+1 cycles per entry ahead of it.
- Push and pop in the same cycle: count is unchanged and the pending mask is updated for both.
- Pointers wrap modulo FIFO_DEPTH.
- Reset (rst=0) is asynchronous and takes effect mid-operation:
  - FIFO is emptied, pointers are 0, starve=0, lu_pending_o=0.
  - lu_ready_o=1, rf_we_o=0, stall_o=0, rf_waddr_o=0, rf_wdata_o=0 while rst=0.
  - Buffered results are discarded. The long-latency unit is reset by the same rst.

## Structure
- Shared package riscv_pkg holds XLEN=32, REG_ADDR_W=5 and the wb-source select encoding (SEL_PIPE, SEL_LU).
- Sub-module wb_result_fifo provides the parameterised FIFO of {rd, data}, with count, full/empty and the pending-mask generation.
- Arbitration, the starve counter and the output mux live in wb_port_arbiter.

## Test plan
- Pipeline only: wb_regwrite_i=1, rd=5, data=0xDEADBEEF with no lu traffic → same cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, stall_o=0.
- Idle drain: lu push rd=7, data=0x1234 at edge t, no pipeline request → cycle t+1 rf write to 7, lu_pending_o bit7 clears after the next edge.
- Starvation: one buffered entry with continuous valid pipeline writes, STARVE_LIMIT=4 → 4 pipeline writes, then a cycle with stall_o=1 writing the lu entry, then the held pipeline write completes.
- Full FIFO: push 2 entries while pipeline writes every cycle → lu_ready_o=0 after 2 accepts, and the third lu_valid_i is held until a pop.
- x0 handling: wb rd=0 and lu rd=0 → rf_we_o stays 0, the lu handshake completes, count and pending stay 0.
- Reset mid-operation: 2 buffered entries, starve=3, rst low asynchronously → lu_ready_o=1, rf_we_o=0 immediately; after release no stale writes occur.
